// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: buffers received bytes, drops framing-error bytes,
// tracks sticky overrun/framing-error flags and raises irq at a fill threshold.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_ferr,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overrun,
    output logic                     ferr,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_overrun;
    logic          r_ferr;
    logic          r_irq;
    logic [7:0]    r_rdData;
    logic          r_rdValid;

    logic          w_pop;
    logic          w_push;
    logic          w_ovrSet;
    logic          w_ferrSet;
    logic [CW-1:0] w_countNext;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte alongside a pop.
    assign w_pop     = rd_en & ~r_empty & ~flush;
    assign w_push    = rx_valid & ~rx_ferr & ~flush & (~r_full | w_pop);
    assign w_ovrSet  = rx_valid & ~rx_ferr & ~flush & r_full & ~w_pop;
    assign w_ferrSet = rx_valid & rx_ferr & ~flush;

    always_comb begin
        w_countNext = r_count;
        if (flush) begin
            w_countNext = '0;
        end else if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_countNext = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wrPtr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
            r_irq     <= 1'b0;
            r_rdData  <= 8'h00;
            r_rdValid <= 1'b0;
        end else begin
            if (flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_ONE;
                end
            end
            r_count   <= w_countNext;
            r_empty   <= (w_countNext == '0);
            r_full    <= (w_countNext == DEPTH_C);
            // Set events beat a simultaneous clear so no error is silently lost.
            r_overrun <= w_ovrSet  | (r_overrun & ~clr_err);
            r_ferr    <= w_ferrSet | (r_ferr & ~clr_err);
            r_irq     <= (r_count >= THRESH_C) | r_overrun | r_ferr;
            r_rdValid <= w_pop;
            if (w_pop) begin
                r_rdData <= r_mem[r_rdPtr];
            end
        end
    end

    assign rd_data  = r_rdData;
    assign rd_valid = r_rdValid;
    assign count    = r_count;
    assign empty    = r_empty;
    assign full     = r_full;
    assign overrun  = r_overrun;
    assign ferr     = r_ferr;
    assign irq      = r_irq;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, range 2..256.
REQ-002 SHALL have parameter THRESH, default 8: fill level that asserts irq; range 1..DEPTH.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-007 SHALL have port rx_ferr  input  1  framing error for the byte strobed this cycle; sampled only with rx_valid.
REQ-008 SHALL have port rd_en  input  1  consumer pop request.
REQ-009 SHALL have port flush  input  1  discards all contents.
REQ-010 SHALL have port clr_err  input  1  clears the sticky overrun and ferr flags.
REQ-011 SHALL have port rd_data  output  8  popped byte, registered.
REQ-012 SHALL have port rd_valid  output  1  one-cycle strobe; rd_data is valid.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
REQ-014 SHALL have ports empty and full  output  1 each  count==0 and count==DEPTH.
REQ-015 SHALL have ports overrun and ferr  output  1 each  sticky error flags.
REQ-016 SHALL have port irq  output  1  registered; high while count>=THRESH, overrun or ferr.

Function
REQ-017 Push SHALL occur when rx_valid=1, rx_ferr=0, flush=0, and either not full or a pop occurs in the same cycle.
REQ-018 Byte with rx_valid=1 and rx_ferr=1 SHALL be discarded and set ferr; it SHALL NOT change count.
REQ-019 rx_valid=1, rx_ferr=0, full=1 with no pop SHALL drop the byte, set overrun, and leave contents unchanged.
REQ-020 Pop SHALL occur when rd_en=1, empty=0 and flush=0; the oldest byte appears on rd_data with rd_valid=1 the following cycle.
REQ-021 rd_en while empty SHALL be ignored: rd_valid=0 next cycle, rd_data holds its previous value, no error flag.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including at full (byte accepted) and at 1.
REQ-023 Simultaneous push and pop at empty SHALL perform the push only; the byte is popped no earlier than the next cycle.
REQ-024 Order SHALL be strict FIFO; read and write pointers wrap modulo DEPTH with no gap or duplicate at wrap.
REQ-025 flush SHALL set count=0 and pointers equal next cycle, override any same-cycle push/pop, produce rd_valid=0, and leave overrun/ferr unchanged.
REQ-026 clr_err SHALL clear overrun and ferr next cycle; a same-cycle set event SHALL win, leaving the flag at 1.
REQ-027 count, empty and full SHALL be registered and reflect all events of the prior cycle; no combinational path from inputs to outputs.
REQ-028 irq SHALL update one cycle after the count/flag change that causes it.
REQ-029 Storage contents SHALL NOT be observable except through pops; storage need not be reset.

Reset
REQ-030 While rst_n=0 at a rising edge: count=0, empty=1, full=0, overrun=0, ferr=0, irq=0, rd_valid=0, rd_data=8'h00, pointers=0.
REQ-031 Reset SHALL take priority over all other inputs; bytes strobed during reset are lost with no flag set.
REQ-032 Reset asserted mid-operation SHALL return the block to the REQ-030 state in one cycle; the first push after release lands at pointer 0.

Verification
REQ-033 Push 8'hA5, 8'h3C, then pop twice -> rd_data 8'hA5 then 8'h3C, each with a one-cycle rd_valid; count 2->1->0; empty=1 at the end.
REQ-034 DEPTH=16: push 16 bytes 0x00..0x0F, then push 0x55 -> full=1, overrun=1, irq=1; 16 pops return 0x00..0x0F and 0x55 never appears.
REQ-035 Full FIFO, push 0x77 with rd_en in the same cycle -> count stays 16, overrun=0; the 17th pop returns 0x77.
REQ-036 Push 20 and pop 20 interleaved across the wrap -> output sequence is identical to input; pop on empty -> rd_valid=0.
REQ-037 rx_valid with rx_ferr=1 (byte 0xEE) -> ferr=1, irq=1, count unchanged; clr_err together with a new ferr byte -> ferr stays 1; clr_err alone -> ferr=0.
REQ-038 5 bytes held, flush asserted with a same-cycle push and rd_en -> count=0, rd_valid=0; assert rst_n=0 mid-stream -> all outputs match REQ-030.
